// File: rtl/sub_pipe_pkg.sv
// Shared constants and slice type for the pipelined subtractor.
package sub_pipe_pkg;

    localparam int SUB_WIDTH  = 16;
    localparam int SUB_SLICE  = 4;
    localparam int SUB_STAGES = SUB_WIDTH / SUB_SLICE;

    typedef logic [SUB_SLICE-1:0] slice_t;

endpackage

// File: rtl/sub_4bit_slice.sv
// Combinational SLICE-bit ripple-borrow subtract: diff = a - b - bin.
module sub_4bit_slice
    import sub_pipe_pkg::*;
#(
    parameter int SLICE = SUB_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] diff,
    output logic             bout
);

    logic br;

    always_comb begin
        diff = '0;
        br   = bin;
        for (int i = 0; i < SLICE; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & (b[i] | br)) | (b[i] & br);
        end
        bout = br;
    end

endmodule

// File: rtl/sub_16bit_pipe.sv
// Pipelined subtractor, one SLICE-bit ripple slice per stage, pipeline-wide stall.
// Optional signed overflow output: define SUB_PIPE_OVERFLOW_EN.
module sub_16bit_pipe
    import sub_pipe_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SUB_PIPE_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    localparam int STAGES = WIDTH / SLICE;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Operand bits not yet consumed when they reach stage k.
        localparam int IW = WIDTH - k*SLICE;

        logic [IW-1:0]          ain, bn;
        logic                   bi;
        logic [SLICE-1:0]       sd;
        logic                   bo;
        // Result accumulates low slices as it moves up, so all bits leave together.
        logic [(k+1)*SLICE-1:0] res;
        logic                   brw, vld;

        sub_4bit_slice #(.SLICE(SLICE)) u_slice (
            .a    (ain[SLICE-1:0]),
            .b    (bn[SLICE-1:0]),
            .bin  (bi),
            .diff (sd),
            .bout (bo)
        );

        if (k == 0) begin : g_src
            assign ain = a;
            assign bn  = b;
            assign bi  = bin;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    res <= '0;
                    brw <= 1'b0;
                    vld <= 1'b0;
                end else if (en) begin
                    res <= sd;
                    brw <= bo;
                    vld <= in_valid;
                end
            end
        end else begin : g_src
            assign ain = g_stg[k-1].g_hi.a_hi;
            assign bn  = g_stg[k-1].g_hi.b_hi;
            assign bi  = g_stg[k-1].brw;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    res <= '0;
                    brw <= 1'b0;
                    vld <= 1'b0;
                end else if (en) begin
                    res <= {sd, g_stg[k-1].res};
                    brw <= bo;
                    vld <= g_stg[k-1].vld;
                end
            end
        end

        if (IW > SLICE) begin : g_hi
            logic [IW-SLICE-1:0] a_hi, b_hi;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (en) begin
                    a_hi <= ain[IW-1:SLICE];
                    b_hi <= bn[IW-1:SLICE];
                end
            end
        end
    end

    assign diff      = g_stg[STAGES-1].res;
    assign bout      = g_stg[STAGES-1].brw;
    assign out_valid = g_stg[STAGES-1].vld;

`ifdef SUB_PIPE_OVERFLOW_EN
    // Operand sign bits registered alongside the top slice to stay aligned with diff.
    logic a_msb, b_msb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (en) begin
            a_msb <= g_stg[STAGES-1].ain[SLICE-1];
            b_msb <= g_stg[STAGES-1].bn[SLICE-1];
        end
    end

    assign ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
`endif

endmodule
